cdb_arbiter: RTL and testbench

Collects completed results from the execution units (ALU, multiplier, divider, load/store queue) and serialises them onto the single common data bus as one registered `cdb_t` per cycle. It sits directly downstream of the functional units and upstream of the ROB, reservation stations and physical register file, which all snoop `cdb_out`. Each source owns a one-entry holding slot, so a unit can retire its result and move on while it waits for a grant.

---
 rtl/rv32i_types.sv | 30 +++
 rtl/cdb_rr_arbiter.sv | 38 +++
 rtl/cdb_arbiter.sv | 105 ++++++++++
 tb/tb_cdb_arbiter.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_types.sv
// Shared core types: the common-data-bus record and the CDB source numbering.
package rv32i_types;

  localparam int NUM_CDB_SRC = 4;

  typedef enum logic [1:0] {
    CDB_SRC_ALU,
    CDB_SRC_MUL,
    CDB_SRC_DIV,
    CDB_SRC_LSQ
  } cdb_src_t;

  typedef struct packed {
    logic        valid;
    logic [5:0]  rob_idx;
    logic [5:0]  pd_s;
    logic [4:0]  rd_s;
    logic [31:0] rd_v;
    logic [31:0] inst;
  } cdb_t;

  // Returns the record with its qualifier forced; payload fields untouched.
  function automatic cdb_t cdb_with_valid(cdb_t c, logic v);
    cdb_t r;
    r       = c;
    r.valid = v;
    return r;
  endfunction

endpackage

// File: rtl/cdb_rr_arbiter.sv
// Combinational one-of-N grant: first request found searching upward from ptr,
// wrapping at NUM_SRC-1. With ptr tied to zero this is plain fixed priority.
module cdb_rr_arbiter #(
  parameter int NUM_SRC = 4,
  parameter int IDX_W   = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_SRC-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_vld
);

  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] cand;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    sum       = '0;
    cand      = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      // ptr is always below NUM_SRC, so one subtraction is enough to wrap.
      sum = {1'b0, ptr} + (IDX_W+1)'(k);
      if (sum >= (IDX_W+1)'(NUM_SRC)) begin
        sum = sum - (IDX_W+1)'(NUM_SRC);
      end
      cand = sum[IDX_W-1:0];
      if (!grant_vld && req[cand]) begin
        grant[cand] = 1'b1;
        grant_idx   = cand;
        grant_vld   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Serialises execution-unit results onto the common data bus, one registered
// broadcast per cycle. Define CDB_RR_ARB_EN for rotating priority; otherwise fixed.
module cdb_arbiter
  import rv32i_types::*;
#(
  parameter int NUM_SRC = NUM_CDB_SRC,
  localparam int IDX_W  = $clog2(NUM_SRC)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic [NUM_SRC-1:0]   src_valid,
  output logic [NUM_SRC-1:0]   src_ready,
  input  cdb_t [NUM_SRC-1:0]   src_data,
  output cdb_t                 cdb_out,
  output logic [IDX_W-1:0]     grant_src
);

  // Handshake: slot i takes src_data[i] on an edge where src_valid[i] && src_ready[i].
  // src_ready never looks at src_valid; a stalled source holds valid and data stable.

  logic [NUM_SRC-1:0] occ_q, occ_d;
  cdb_t [NUM_SRC-1:0] slot_q, slot_d;
  cdb_t               cdb_q, cdb_d;
  logic [IDX_W-1:0]   grant_src_q, grant_src_d;

  logic [NUM_SRC-1:0] grant;
  logic [NUM_SRC-1:0] accept;
  logic [IDX_W-1:0]   grant_idx;
  logic               grant_vld;
  logic [IDX_W-1:0]   arb_ptr;

`ifdef CDB_RR_ARB_EN
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;

  // A grant cancelled by flush did not broadcast, so it does not rotate the pointer.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (grant_vld && !flush) begin
      rr_ptr_d = (grant_idx == IDX_W'(NUM_SRC-1)) ? '0 : grant_idx + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign arb_ptr = rr_ptr_q;
`else
  assign arb_ptr = '0;
`endif

  cdb_rr_arbiter #(
    .NUM_SRC (NUM_SRC),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req       (occ_q),
    .ptr       (arb_ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_vld (grant_vld)
  );

  // A granted slot is leaving this cycle, so it can be refilled in the same edge.
  assign src_ready = flush ? '0 : (~occ_q | grant);
  assign accept    = src_valid & src_ready;

  always_comb begin
    occ_d = flush ? '0 : ((occ_q & ~grant) | accept);
    for (int i = 0; i < NUM_SRC; i++) begin
      slot_d[i] = accept[i] ? src_data[i] : slot_q[i];
    end
  end

  always_comb begin
    cdb_d       = cdb_with_valid(cdb_q, 1'b0);
    grant_src_d = grant_src_q;
    if (grant_vld && !flush) begin
      cdb_d       = cdb_with_valid(slot_q[grant_idx], 1'b1);
      grant_src_d = grant_idx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ_q       <= '0;
      slot_q      <= '0;
      cdb_q       <= '0;
      grant_src_q <= '0;
    end else begin
      occ_q       <= occ_d;
      slot_q      <= slot_d;
      cdb_q       <= cdb_d;
      grant_src_q <= grant_src_d;
    end
  end

  assign cdb_out   = cdb_q;
  assign grant_src = grant_src_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Randomised scoreboard bench for cdb_arbiter against a slot-level reference model.
module tb_cdb_arbiter;
  import rv32i_types::*;

  localparam int N  = NUM_CDB_SRC;
  localparam int IW = $clog2(N);
  localparam int W  = IW + $bits(cdb_t);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  logic flush;
  logic [N-1:0] src_valid;
  logic [N-1:0] src_ready;
  cdb_t [N-1:0] src_data;
  cdb_t         cdb_out;
  logic [IW-1:0] grant_src;

  always #5 clk = ~clk;

  cdb_arbiter #(.NUM_SRC(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .src_valid (src_valid),
    .src_ready (src_ready),
    .src_data  (src_data),
    .cdb_out   (cdb_out),
    .grant_src (grant_src)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Scoreboard entry: {source index, broadcast record}.
  logic [W-1:0] exp_q[$];
  logic         exp_bcast = 1'b0;
  logic         mon_en    = 1'b0;
  logic [W-1:0] mon_e;

  // Reference model: which slots hold a result, what they hold, where the search starts.
  bit   m_occ[N];
  cdb_t m_slot[N];
  int   m_ptr;

  // Source side: a result waiting to be handed over, held until accepted.
  bit   pend[N];
  cdb_t pend_data[N];

  function automatic cdb_t rand_cdb();
    cdb_t c;
    c.valid   = 1'($urandom_range(0, 1));
    c.rob_idx = 6'($urandom_range(0, 63));
    c.pd_s    = 6'($urandom_range(0, 63));
    c.rd_s    = 5'($urandom_range(0, 31));
    c.rd_v    = $urandom;
    c.inst    = $urandom;
    return c;
  endfunction

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h want %h at %0t", name, got, want, $time);
    end
  endtask

  task automatic offer(input int i, input cdb_t d);
    pend[i]      = 1'b1;
    pend_data[i] = d;
  endtask

  task automatic model_reset();
    m_ptr = 0;
    for (int i = 0; i < N; i++) begin
      m_occ[i] = 1'b0;
      pend[i]  = 1'b0;
    end
    exp_q.delete();
    exp_bcast = 1'b0;
  endtask

  // ---------------- driver: one cycle of stimulus plus model update ----------------
  task automatic tick(input logic fl);
    int           g;
    logic [N-1:0] exp_rdy;
    cdb_t         c;
    @(negedge clk);
    flush = fl;
    for (int i = 0; i < N; i++) begin
      src_valid[i] = pend[i];
      src_data[i]  = pend[i] ? pend_data[i] : rand_cdb();
    end
    #1;
    g = -1;
    for (int k = 0; k < N; k++) begin
      if (g < 0 && m_occ[(m_ptr + k) % N]) g = (m_ptr + k) % N;
    end
    for (int i = 0; i < N; i++) exp_rdy[i] = !fl && (!m_occ[i] || i == g);
    chk("src_ready", 128'(src_ready), 128'(exp_rdy));
    if (!fl && g >= 0) begin
      c = m_slot[g];
      c.valid = 1'b1;
      exp_q.push_back({IW'(g), c});
      exp_bcast = 1'b1;
`ifdef CDB_RR_ARB_EN
      m_ptr = (g + 1) % N;
`endif
    end else begin
      exp_bcast = 1'b0;
    end
    if (g >= 0) m_occ[g] = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (pend[i] && exp_rdy[i]) begin
        m_occ[i]  = 1'b1;
        m_slot[i] = pend_data[i];
        pend[i]   = 1'b0;
      end
    end
    if (fl) begin
      for (int i = 0; i < N; i++) begin
        m_occ[i] = 1'b0;
        pend[i]  = 1'b0;
      end
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (mon_en) begin
      n_tests++;
      if (cdb_out.valid !== exp_bcast) begin
        n_fail++;
        $display("FAIL bcast_valid: got %b want %b at %0t", cdb_out.valid, exp_bcast, $time);
      end
      if (cdb_out.valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL bcast_extra: got %h want none at %0t", {grant_src, cdb_out}, $time);
        end else begin
          mon_e = exp_q.pop_front();
          n_tests++;
          if ({grant_src, cdb_out} !== mon_e) begin
            n_fail++;
            $display("FAIL bcast_data: got %h want %h at %0t", {grant_src, cdb_out}, mon_e, $time);
          end
        end
      end
    end
  end

  // ---------------- sequence ----------------
  initial begin
    cdb_t c;
    rst       = 1'b1;
    flush     = 1'b0;
    src_valid = '0;
    src_data  = '0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset_cdb_out", 128'(cdb_out), 128'(0));
    chk("reset_grant_src", 128'(grant_src), 128'(0));
    chk("reset_src_ready", 128'(src_ready), 128'({N{1'b1}}));
    rst    = 1'b0;
    mon_en = 1'b1;

    // Single ALU result.
    c = '0;
    c.pd_s = 6'd5; c.rd_s = 5'd3; c.rd_v = 32'h1234; c.rob_idx = 6'd9; c.inst = 32'h13;
    offer(0, c);
    repeat (5) tick(1'b0);

    // All four sources at once.
    for (int i = 0; i < N; i++) offer(i, rand_cdb());
    repeat (7) tick(1'b0);

    // Source 0 refills every cycle while source 1 waits.
    offer(1, rand_cdb());
    for (int n = 0; n < 12; n++) begin
      if (!pend[0]) offer(0, rand_cdb());
      tick(1'b0);
    end
    tick(1'b1);
    repeat (2) tick(1'b0);

    // Backpressure with a recognisable MUL payload.
    offer(2, rand_cdb());
    tick(1'b0);
    c = rand_cdb();
    c.rd_v = 32'hDEADBEEF;
    offer(1, c);
    offer(2, rand_cdb());
    tick(1'b0);
    offer(1, rand_cdb());
    offer(2, rand_cdb());
    repeat (7) tick(1'b0);

    // Flush with three slots occupied.
    for (int i = 0; i < 3; i++) offer(i, rand_cdb());
    tick(1'b0);
    tick(1'b1);
    repeat (5) tick(1'b0);

    // Asynchronous reset between edges during a burst.
    for (int i = 0; i < N; i++) offer(i, rand_cdb());
    repeat (2) tick(1'b0);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_cdb_out", 128'(cdb_out), 128'(0));
    chk("async_rst_grant_src", 128'(grant_src), 128'(0));
    chk("async_rst_src_ready", 128'(src_ready), 128'({N{1'b1}}));
    #1 rst = 1'b0;
    model_reset();
    repeat (4) tick(1'b0);

    // Random traffic with occasional flushes.
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 99) < 40) offer(i, rand_cdb());
      end
      tick($urandom_range(0, 99) < 3);
    end
    repeat (12) tick(1'b0);
    @(negedge clk);
    #1;
    chk("scoreboard_drained", 128'(exp_q.size()), 128'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
